// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, per-button debounce FSM and a
// lowest-index-first press-strobe arbiter. Define BTN_AUTOREPEAT_EN to add auto-repeat.
module button_conditioner #(
  parameter int N_PULSADORES    = 3,
  parameter int NB_COUNT        = 20,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_PULSADORES-1:0] i_pulsadores_raw,
  output logic [N_PULSADORES-1:0] o_pulsadores,
  output logic [N_PULSADORES-1:0] o_level
);

  // o_pulsadores carries no handshake: a set bit is a single-cycle strobe that the
  // consumer must take in the cycle it is presented; there is no ready/backpressure.

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [NB_COUNT-1:0] DEB_LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** NB_COUNT) - 1 || REPEAT_CYCLES < 1)
  begin : g_bad_param
    $error("button_conditioner: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int NB_REP = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [NB_REP-1:0] REP_LAST = NB_REP'(REPEAT_CYCLES - 1);
`endif

  logic [N_PULSADORES-1:0] sync1_q;
  logic [N_PULSADORES-1:0] sync_q;
  logic [N_PULSADORES-1:0] press_set;
  logic [N_PULSADORES-1:0] pending_q;
  logic [N_PULSADORES-1:0] grant;
  logic [N_PULSADORES-1:0] strobe_q;

  // Raw levels touch nothing but the first synchronizer flop.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= i_pulsadores_raw;
      sync_q  <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_PULSADORES; g++) begin : g_btn
    state_t              state_q;
    logic [NB_COUNT-1:0] cnt_q;
    logic                level_q;
    logic                cnt_done;
    logic                deb_set;
    logic                rep_set;

    assign cnt_done = (cnt_q == DEB_LAST);

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        case (state_q)
          RELEASED: begin
            if (sync_q[g]) begin
              state_q <= PRESS_CHK;
              cnt_q   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!sync_q[g]) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_done) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + NB_COUNT'(1);
            end
          end
          PRESSED: begin
            if (!sync_q[g]) begin
              state_q <= RELEASE_CHK;
              cnt_q   <= '0;
            end
          end
          RELEASE_CHK: begin
            if (sync_q[g]) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_done) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + NB_COUNT'(1);
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    // Only a completed press raises a request; release completion never does.
    assign deb_set = (state_q == PRESS_CHK) && sync_q[g] && cnt_done;

`ifdef BTN_AUTOREPEAT_EN
    logic [NB_REP-1:0] rep_q;

    // Counts whole cycles spent in PRESSED; restarts from zero on every re-entry.
    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        rep_q <= '0;
      end else if (state_q == PRESSED) begin
        rep_q <= (rep_q == REP_LAST) ? '0 : rep_q + NB_REP'(1);
      end else begin
        rep_q <= '0;
      end
    end

    assign rep_set = (state_q == PRESSED) && (rep_q == REP_LAST);
`else
    assign rep_set = 1'b0;
`endif

    assign press_set[g] = deb_set | rep_set;
    assign o_level[g]   = level_q;
  end

  // Isolate the lowest set pending bit.
  always_comb begin
    grant = pending_q & (~pending_q + N_PULSADORES'(1));
  end

  // A press completing on the cycle its earlier request is granted stays pending.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pending_q <= '0;
      strobe_q  <= '0;
    end else begin
      pending_q <= (pending_q & ~grant) | press_set;
      strobe_q  <= grant;
    end
  end

  assign o_pulsadores = strobe_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length debounce reference model feeding an
// expected-strobe queue, a negedge monitor, directed scenarios and random presses.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int N = 3;
  localparam int D = 4;
  localparam int R = 10;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw   = '0;
  logic [N-1:0] o_p;
  logic [N-1:0] o_l;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Entry layout: {cycle stamp, expected strobe}
  logic [34:0] exp_q[$];

  // Reference model state
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] h1      = '0;
  logic [N-1:0] h2      = '0;
  int           m_run[N];
  int           m_age[N];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  button_conditioner #(
    .N_PULSADORES   (N),
    .NB_COUNT       (8),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_pulsadores_raw(raw),
    .o_pulsadores    (o_p),
    .o_level         (o_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A button's level flips once the synchronized input has disagreed with it for
  // D+1 consecutive samples; every press queues one request, granted lowest index first.
  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] smp;
    logic [N-1:0] grant;
    bit           held_steady;
    if (!rst_n) begin
      m_level = '0;
      m_pend  = '0;
      h1      = '0;
      h2      = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
      exp_q.delete();
    end else begin
      cyc++;
      smp = h2;
      h2  = h1;
      h1  = raw;
      grant = '0;
      for (int i = 0; i < N; i++)
        if (m_pend[i] && grant == '0) grant[i] = 1'b1;
      m_pend = m_pend & ~grant;
      for (int i = 0; i < N; i++) begin
        held_steady = m_level[i] && (m_run[i] == 0);
        if (smp[i] != m_level[i]) m_run[i]++;
        else m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
        if (held_steady) begin
          m_age[i]++;
          if (m_age[i] % R == 0) m_pend[i] = 1'b1;
        end else begin
          m_age[i] = 0;
        end
`else
        if (held_steady) m_age[i]++;
        else m_age[i] = 0;
`endif
        if (m_run[i] == D + 1) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          if (m_level[i]) begin
            m_pend[i] = 1'b1;
            m_age[i]  = 0;
          end
        end
      end
      if (grant != '0) exp_q.push_back({cyc[31:0], grant});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst_n) begin
      chk("reset_strobe", o_p, '0);
      chk("reset_level", o_l, '0);
    end else begin
      chk("level", o_l, m_level);
      while (exp_q.size() > 0 && int'(exp_q[0][34:3]) < cyc) begin
        e = exp_q.pop_front();
        chk("strobe_missing", 32'h0, e[2:0]);
      end
      if (o_p != '0) begin
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", o_p, '0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_value", o_p, e[2:0]);
          chk("strobe_cycle", cyc, e[34:3]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][34:3]) == cyc) begin
        e = exp_q.pop_front();
        chk("strobe_missing", o_p, e[2:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clean_step_bit0();
    raw[0] = 1'b1;
    cycles(6);
    chk("step_level_early", o_l[0], 1'b0);
    cycles(1);
    chk("step_level_set", o_l[0], 1'b1);
    chk("step_no_strobe_yet", o_p, 3'b000);
    cycles(1);
    chk("step_strobe", o_p, 3'b001);
    cycles(1);
    chk("step_strobe_width", o_p, 3'b000);
    raw[0] = 1'b0;
    cycles(14);
    chk("step_release_level", o_l[0], 1'b0);
  endtask

  task automatic bounce_bit1();
    int n_bounce = 0;
    int n_held   = 0;
    for (int k = 0; k < 4; k++) begin
      raw[1] = (k % 2 == 0);
      @(negedge clk);
      if (o_p != '0) n_bounce++;
    end
    raw[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_p[1]) n_held++;
    end
    chk("bounce_no_strobe", n_bounce, 0);
    chk("bounce_single_strobe", n_held, 1);
    raw[1] = 1'b0;
    cycles(14);
  endtask

  task automatic simultaneous_0_2();
    logic [N-1:0] seen[$];
    raw = 3'b101;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (o_p != '0) seen.push_back(o_p);
    end
    chk("simul_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("simul_first", seen[0], 3'b001);
      chk("simul_second", seen[1], 3'b100);
    end
    raw = '0;
    cycles(14);
  endtask

  task automatic reset_mid_debounce();
    int k_b0 = -1;
    int k_b1 = -1;
    raw[1] = 1'b1;
    cycles(12);
    raw[0] = 1'b1;
    cycles(4);
    chk("prereset_level", o_l, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_level", o_l, 3'b000);
    chk("async_reset_strobe", o_p, 3'b000);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (o_p == 3'b001) k_b0 = k;
      if (o_p == 3'b010) k_b1 = k;
    end
    chk("rst_repress_bit0", k_b0, 8);
    chk("rst_repress_bit1", k_b1, 9);
    raw = '0;
    cycles(14);
  endtask

  task automatic hold_bit2();
    int n_held = 0;
    int n_rel  = 0;
    raw[2] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_p[2]) n_held++;
    end
    raw[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_p[2]) n_rel++;
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("hold_strobes", n_held, 4);
`else
    chk("hold_strobes", n_held, 1);
`endif
    chk("release_no_strobe", n_rel, 0);
  endtask

  task automatic random_phase(input int n);
    int left[N];
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0) begin
          raw[i]  = 1'($urandom_range(0, 1));
          left[i] = $urandom_range(1, 12);
        end
        left[i]--;
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    raw   = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    clean_step_bit0();
    bounce_bit1();
    simultaneous_0_2();
    reset_mid_debounce();
    hold_bit2();
    random_phase(2000);
    raw = '0;
    cycles(30);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
